// File: rtl/axis_bram_pkg.sv
// Shared constants and FSM state type for the AXIS-to-BRAM write path.
package axis_bram_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int WORDS_PER_LINE = 36;
    localparam int LINE_WIDTH     = DATA_WIDTH * WORDS_PER_LINE;
    localparam int ADDR_WIDTH     = 12;
    localparam int CNT_WIDTH      = $clog2(WORDS_PER_LINE);

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/line_shift_reg.sv
// Wide line accumulator: each beat is loaded into its own slot, selected by index.
module line_shift_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int WORDS      = 36,
    parameter int IDX_WIDTH  = $clog2(WORDS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        load,
    input  logic [IDX_WIDTH-1:0]        idx,
    input  logic [DATA_WIDTH-1:0]       din,
    output logic [DATA_WIDTH*WORDS-1:0] line
);

    // Clear wins over load so a discarded partial line never leaks a late beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line <= '0;
        end else if (clear) begin
            line <= '0;
        end else if (load) begin
            line[idx*DATA_WIDTH +: DATA_WIDTH] <= din;
        end
    end

endmodule

// File: rtl/axis_bram_line_packer.sv
// Packs 32-bit AXIS beats into 1152-bit lines and writes them to successive
// BRAM addresses inside a reloadable [start_addr, end_addr] window.
module axis_bram_line_packer
    import axis_bram_pkg::*;
(
    input  logic                    s00_axis_aclk,
    input  logic                    s00_axis_areset,
    input  logic                    reload,
    input  logic [ADDR_WIDTH-1:0]   start_addr,
    input  logic [ADDR_WIDTH-1:0]   end_addr,
    input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s00_axis_tstrb,
    input  logic                    s00_axis_tvalid,
    input  logic                    s00_axis_tlast,
    output logic                    s00_axis_tready,
    output logic                    bram_en,
    output logic                    bram_wen,
    output logic [ADDR_WIDTH-1:0]   bram_addr,
    output logic [LINE_WIDTH-1:0]   bram_din,
    output logic                    done,
    output logic [ADDR_WIDTH:0]     lines_written
);

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] end_q;
    logic [CNT_WIDTH-1:0]  word_cnt;
    logic                  last_seen;
    logic                  beat_ok;
    logic                  line_clear;
    logic [LINE_WIDTH-1:0] line_q;
    logic                  unused_tstrb;

    assign unused_tstrb = ^s00_axis_tstrb;
    assign beat_ok      = s00_axis_tvalid && s00_axis_tready;
    assign line_clear   = reload || (state == WRITE);
    assign bram_addr    = cur_addr;
    assign bram_din     = line_q;

    line_shift_reg #(
        .DATA_WIDTH(DATA_WIDTH),
        .WORDS     (WORDS_PER_LINE)
    ) u_line (
        .clk  (s00_axis_aclk),
        .rst  (s00_axis_areset),
        .clear(line_clear),
        .load (beat_ok),
        .idx  (word_cnt),
        .din  (s00_axis_tdata),
        .line (line_q)
    );

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // reload overrides every state, including the single WRITE cycle.
    always_comb begin
        next_state = state;
        if (reload) begin
            next_state = FILL;
        end else begin
            case (state)
                FILL: begin
                    if (beat_ok && (word_cnt == LAST_IDX || s00_axis_tlast)) begin
                        next_state = WRITE;
                    end
                end
                WRITE: begin
                    if (last_seen || cur_addr == end_q) begin
                        next_state = DONE;
                    end else begin
                        next_state = FILL;
                    end
                end
                default: next_state = state;
            endcase
        end
    end

    always_comb begin
        s00_axis_tready = 1'b0;
        bram_en         = 1'b0;
        bram_wen        = 1'b0;
        done            = 1'b0;
        case (state)
            FILL:  s00_axis_tready = 1'b1;
            WRITE: begin
                bram_en  = 1'b1;
                bram_wen = 1'b1;
            end
            DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // The address advances only after a write that leaves the window open; it
    // wraps naturally at 2^ADDR_WIDTH so end_addr < start_addr is legal.
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            cur_addr      <= '0;
            end_q         <= '0;
            word_cnt      <= '0;
            last_seen     <= 1'b0;
            lines_written <= '0;
        end else if (reload) begin
            cur_addr      <= start_addr;
            end_q         <= end_addr;
            word_cnt      <= '0;
            last_seen     <= 1'b0;
            lines_written <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (beat_ok) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (s00_axis_tlast) begin
                            last_seen <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    lines_written <= lines_written + 1'b1;
                    word_cnt      <= '0;
                    last_seen     <= 1'b0;
                    if (!last_seen && cur_addr != end_q) begin
                        cur_addr <= cur_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_bram_line_packer.sv
// Self-checking bench for axis_bram_line_packer: vector table plus scoreboard of expected BRAM writes.
module tb_axis_bram_line_packer;
    import axis_bram_pkg::*;

    logic                    s00_axis_aclk = 1'b0;
    logic                    s00_axis_areset;
    logic                    reload;
    logic [ADDR_WIDTH-1:0]   start_addr;
    logic [ADDR_WIDTH-1:0]   end_addr;
    logic [DATA_WIDTH-1:0]   s00_axis_tdata;
    logic [DATA_WIDTH/8-1:0] s00_axis_tstrb;
    logic                    s00_axis_tvalid;
    logic                    s00_axis_tlast;
    logic                    s00_axis_tready;
    logic                    bram_en;
    logic                    bram_wen;
    logic [ADDR_WIDTH-1:0]   bram_addr;
    logic [LINE_WIDTH-1:0]   bram_din;
    logic                    done;
    logic [ADDR_WIDTH:0]     lines_written;

    axis_bram_line_packer dut (
        .s00_axis_aclk  (s00_axis_aclk),
        .s00_axis_areset(s00_axis_areset),
        .reload         (reload),
        .start_addr     (start_addr),
        .end_addr       (end_addr),
        .s00_axis_tdata (s00_axis_tdata),
        .s00_axis_tstrb (s00_axis_tstrb),
        .s00_axis_tvalid(s00_axis_tvalid),
        .s00_axis_tlast (s00_axis_tlast),
        .s00_axis_tready(s00_axis_tready),
        .bram_en        (bram_en),
        .bram_wen       (bram_wen),
        .bram_addr      (bram_addr),
        .bram_din       (bram_din),
        .done           (done),
        .lines_written  (lines_written)
    );

    always #5 s00_axis_aclk = ~s00_axis_aclk;

    typedef struct {
        logic [ADDR_WIDTH-1:0] addr;
        logic [LINE_WIDTH-1:0] data;
    } wr_t;

    typedef struct {
        logic [ADDR_WIDTH-1:0] start_a;
        logic [ADDR_WIDTH-1:0] end_a;
        int                    nbeats;
        bit                    last_on_final;
        bit                    gap;
        int                    pat;
        int                    exp_writes;
        bit                    exp_done;
        logic [ADDR_WIDTH:0]   exp_lw;
    } vec_t;

    wr_t                   exp_q[$];
    int                    tests_run    = 0;
    int                    tests_failed = 0;
    int                    wr_count     = 0;
    logic [LINE_WIDTH-1:0] m_line;
    int                    m_cnt;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [ADDR_WIDTH-1:0] m_end;
    vec_t                  vecs[7];

    task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic void model_reload(input logic [ADDR_WIDTH-1:0] s, input logic [ADDR_WIDTH-1:0] e);
        m_addr = s;
        m_end  = e;
        m_line = '0;
        m_cnt  = 0;
    endfunction

    // Reference packer: builds the expected line and queues it once it is complete.
    function automatic void model_beat(input logic [DATA_WIDTH-1:0] d, input bit l);
        wr_t w;
        m_line[m_cnt*DATA_WIDTH +: DATA_WIDTH] = d;
        m_cnt++;
        if (m_cnt == WORDS_PER_LINE || l) begin
            w.addr = m_addr;
            w.data = m_line;
            exp_q.push_back(w);
            m_line = '0;
            m_cnt  = 0;
            if (!(l || m_addr == m_end)) begin
                m_addr = m_addr + 1'b1;
            end
        end
    endfunction

    function automatic logic [DATA_WIDTH-1:0] beat_data(input int pat, input int k);
        case (pat)
            0:       return (k == 0) ? 32'hBBBB_BBBB : ((k % 2 == 1) ? 32'hFFFF_FFFF : 32'hDDDD_DDDD);
            1:       return DATA_WIDTH'(k + 1);
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard side: every BRAM write must match the oldest queued expectation.
    always @(negedge s00_axis_aclk) begin
        if (!s00_axis_areset && bram_wen) begin
            wr_t e;
            wr_count++;
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_write: got write at addr %0h, expected none", bram_addr);
            end else begin
                e = exp_q.pop_front();
                check_output("write_addr", 64'(bram_addr), 64'(e.addr));
                tests_run++;
                if (bram_din !== e.data) begin
                    tests_failed++;
                    for (int s = 0; s < WORDS_PER_LINE; s++) begin
                        if (bram_din[s*DATA_WIDTH +: DATA_WIDTH] !== e.data[s*DATA_WIDTH +: DATA_WIDTH]) begin
                            $display("[TB] FAIL write_data slot %0d: got %h, expected %h", s,
                                     bram_din[s*DATA_WIDTH +: DATA_WIDTH], e.data[s*DATA_WIDTH +: DATA_WIDTH]);
                            break;
                        end
                    end
                end
            end
        end
    end

    task automatic do_reload(input logic [ADDR_WIDTH-1:0] s, input logic [ADDR_WIDTH-1:0] e);
        reload     = 1'b1;
        start_addr = s;
        end_addr   = e;
        @(negedge s00_axis_aclk);
        reload = 1'b0;
        model_reload(s, e);
    endtask

    task automatic drive_beat(input logic [DATA_WIDTH-1:0] d, input bit l);
        int cycles = 0;
        s00_axis_tvalid = 1'b1;
        s00_axis_tdata  = d;
        s00_axis_tlast  = l;
        while (!s00_axis_tready && cycles < 50) begin
            @(negedge s00_axis_aclk);
            cycles++;
        end
        if (!s00_axis_tready) begin
            check_output("beat_accept_timeout", 64'(s00_axis_tready), 64'd1);
        end else begin
            model_beat(d, l);
            @(negedge s00_axis_aclk);
        end
        s00_axis_tvalid = 1'b0;
        s00_axis_tlast  = 1'b0;
    endtask

    task automatic drain(input string name);
        int c = 0;
        while (exp_q.size() != 0 && c < 20) begin
            @(negedge s00_axis_aclk);
            c++;
        end
        check_output(name, 64'(exp_q.size()), 64'd0);
        @(negedge s00_axis_aclk);
    endtask

    task automatic hold_refused(input string name, input int n);
        int seen = 0;
        s00_axis_tvalid = 1'b1;
        s00_axis_tdata  = 32'hDEAD_BEEF;
        for (int i = 0; i < n; i++) begin
            if (s00_axis_tready) seen++;
            @(negedge s00_axis_aclk);
        end
        s00_axis_tvalid = 1'b0;
        check_output(name, 64'(seen), 64'd0);
    endtask

    task automatic apply_stimulus(input int idx, input vec_t v);
        int w0;
        do_reload(v.start_a, v.end_a);
        w0 = wr_count;
        for (int k = 0; k < v.nbeats; k++) begin
            if (v.gap) @(negedge s00_axis_aclk);
            drive_beat(beat_data(v.pat, k), v.last_on_final && (k == v.nbeats - 1));
        end
        drain($sformatf("vec%0d_drain", idx));
        check_output($sformatf("vec%0d_writes", idx), 64'(wr_count - w0), 64'(v.exp_writes));
        check_output($sformatf("vec%0d_done", idx), 64'(done), 64'(v.exp_done));
        check_output($sformatf("vec%0d_lines_written", idx), 64'(lines_written), 64'(v.exp_lw));
        if (v.exp_done) hold_refused($sformatf("vec%0d_tready_in_done", idx), 8);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w0;
        vecs[0] = '{12'h000, 12'h008, 36,  1'b0, 1'b0, 0, 1, 1'b0, 13'd1};
        vecs[1] = '{12'h000, 12'h001, 72,  1'b0, 1'b0, 2, 2, 1'b1, 13'd2};
        vecs[2] = '{12'h004, 12'h008, 10,  1'b1, 1'b0, 1, 1, 1'b1, 13'd1};
        vecs[3] = '{12'hFFF, 12'h001, 108, 1'b0, 1'b0, 2, 3, 1'b1, 13'd3};
        vecs[4] = '{12'h000, 12'h008, 36,  1'b0, 1'b1, 0, 1, 1'b0, 13'd1};
        vecs[5] = '{12'h010, 12'h020, 36,  1'b1, 1'b0, 1, 1, 1'b1, 13'd1};
        vecs[6] = '{12'h020, 12'h020, 36,  1'b0, 1'b1, 2, 1, 1'b1, 13'd1};

        s00_axis_areset = 1'b1;
        reload          = 1'b0;
        start_addr      = '0;
        end_addr        = '0;
        s00_axis_tdata  = '0;
        s00_axis_tstrb  = '1;
        s00_axis_tvalid = 1'b0;
        s00_axis_tlast  = 1'b0;
        model_reload('0, '0);
        repeat (3) @(negedge s00_axis_aclk);
        check_output("reset_ctrl", 64'({s00_axis_tready, bram_en, bram_wen, done, bram_addr, lines_written}), 64'd0);
        check_output("reset_din", 64'(|bram_din), 64'd0);
        s00_axis_areset = 1'b0;
        @(negedge s00_axis_aclk);
        hold_refused("idle_tready", 4);

        for (int i = 0; i < 7; i++) begin
            apply_stimulus(i, vecs[i]);
        end

        // Reload after a partial line: the first 20 beats must be dropped.
        do_reload(12'h000, 12'h008);
        for (int k = 0; k < 20; k++) drive_beat(32'hA5A5_0000 | 32'(k), 1'b0);
        do_reload(12'h000, 12'h008);
        for (int k = 0; k < 36; k++) drive_beat(32'h5A5A_0000 | 32'(k), 1'b0);
        drain("midfill_reload_drain");
        check_output("midfill_reload_lines_written", 64'(lines_written), 64'd1);

        // Reload during the WRITE cycle: that write still lands, counters restart.
        do_reload(12'h000, 12'h008);
        for (int k = 0; k < 36; k++) drive_beat($urandom, 1'b0);
        do_reload(12'h007, 12'h007);
        check_output("write_reload_lines_written", 64'(lines_written), 64'd0);
        check_output("write_reload_tready", 64'(s00_axis_tready), 64'd1);
        check_output("write_reload_drain", 64'(exp_q.size()), 64'd0);
        for (int k = 0; k < 36; k++) drive_beat($urandom, 1'b0);
        drain("write_reload_second_drain");
        check_output("write_reload_done", 64'(done), 64'd1);
        check_output("write_reload_second_lines", 64'(lines_written), 64'd1);

        // Async reset in the middle of a line: nothing is written afterwards.
        do_reload(12'h000, 12'h008);
        for (int k = 0; k < 20; k++) drive_beat(32'hC0DE_0000 | 32'(k), 1'b0);
        s00_axis_areset = 1'b1;
        @(negedge s00_axis_aclk);
        s00_axis_areset = 1'b0;
        model_reload('0, '0);
        w0 = wr_count;
        check_output("midfill_reset_ctrl", 64'({s00_axis_tready, bram_en, bram_wen, done, bram_addr, lines_written}), 64'd0);
        check_output("midfill_reset_din", 64'(|bram_din), 64'd0);
        hold_refused("midfill_reset_tready", 40);
        check_output("midfill_reset_writes", 64'(wr_count - w0), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
